// File: rtl/sm_cpu_config.sv
// Shared schoolMIPS configuration: opcode constants, fetch FIFO entry layout,
// fetch FSM state encoding and small decode helpers.
package sm_cpu_config;

  localparam logic [5:0]  OP_BEQ  = 6'b000100;
  localparam logic [5:0]  OP_BNE  = 6'b000101;
  localparam logic [31:0] PC_STEP = 32'd4;

  // One prefetch buffer entry; cmd/is_branch are only stored when predecode is built in
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [11:0] cmd;
    logic        is_branch;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_t;

  // Command encoding consumed by the control unit: {opcode, funct}
  function automatic logic [11:0] make_cmd(input logic [31:0] word);
    return {word[31:26], word[5:0]};
  endfunction

  function automatic logic cmd_is_branch(input logic [11:0] cmd);
    return (cmd[11:6] == OP_BEQ) || (cmd[11:6] == OP_BNE);
  endfunction

endpackage

// File: rtl/sm_fetch_fifo.sv
// Prefetch buffer: power-of-two depth synchronous FIFO with flush.
// Head is read straight from the register array so a pushed word is visible
// the cycle after the push.
module sm_fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  // Full-with-pop still accepts a push: the freed slot is the one written
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage write; contents need no reset since occupancy gates visibility
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointer and occupancy bookkeeping; flush wins over push and pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

endmodule

// File: rtl/sm_fetch_unit.sv
// schoolMIPS instruction fetch stage: one outstanding imem request, prefetch
// FIFO, valid/ready instruction output and redirect with stale-response drop.
// Build option: SM_FETCH_PREDECODE_EN stores the {opcode,funct} command and a
// branch flag per entry; without it instr_cmd/instr_is_branch read as 0.
module sm_fetch_unit #(
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [11:0] instr_cmd,
  output logic        instr_is_branch
);
  import sm_cpu_config::*;

`ifdef SM_FETCH_PREDECODE_EN
  localparam int ENTRY_W = $bits(fetch_entry_t);
`else
  localparam int ENTRY_W = 64;
`endif
  localparam int              CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  fetch_state_t       r_state, w_state_next;
  logic [31:0]        r_fetch_pc, w_fetch_pc_next;
  logic [31:0]        r_drop_addr, w_drop_addr_next;
  logic               w_push, w_pop, w_full, w_empty;
  logic [CNT_W-1:0]   w_count;
  logic [ENTRY_W-1:0] w_push_data, w_head_data;
  logic [31:0]        w_redirect_pc;
  logic               w_unused_lsbs;

  assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
  assign w_unused_lsbs = ^redirect_pc[1:0];
  assign w_pop         = !w_empty && instr_ready;
  assign instr_valid   = !w_empty;
  assign imem_req      = (r_state != ST_IDLE);
  // While dropping, the stale request keeps its original address until acked
  assign imem_addr     = (r_state == ST_DROP) ? r_drop_addr : r_fetch_pc;

`ifdef SM_FETCH_PREDECODE_EN
  logic [11:0]  w_push_cmd;
  fetch_entry_t w_head_entry;
  assign w_push_cmd      = make_cmd(imem_rdata);
  assign w_push_data     = {imem_rdata, r_fetch_pc, w_push_cmd, cmd_is_branch(w_push_cmd)};
  assign w_head_entry    = fetch_entry_t'(w_head_data);
  assign instr           = w_empty ? 32'd0 : w_head_entry.instr;
  assign instr_pc        = w_empty ? 32'd0 : w_head_entry.pc;
  assign instr_cmd       = w_empty ? 12'd0 : w_head_entry.cmd;
  assign instr_is_branch = !w_empty && w_head_entry.is_branch;
`else
  assign w_push_data     = {imem_rdata, r_fetch_pc};
  assign instr           = w_empty ? 32'd0 : w_head_data[63:32];
  assign instr_pc        = w_empty ? 32'd0 : w_head_data[31:0];
  assign instr_cmd       = 12'd0;
  assign instr_is_branch = 1'b0;
`endif

  sm_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (redirect_valid),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (w_head_data),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  // Fetch FSM state, fetch PC and held stale-request address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_fetch_pc  <= RESET_PC;
      r_drop_addr <= RESET_PC;
    end else begin
      r_state     <= w_state_next;
      r_fetch_pc  <= w_fetch_pc_next;
      r_drop_addr <= w_drop_addr_next;
    end
  end

  // Next-state logic; a slot is reserved on entering REQ so an ack always fits
  always_comb begin
    w_state_next     = r_state;
    w_fetch_pc_next  = r_fetch_pc;
    w_drop_addr_next = r_drop_addr;
    w_push           = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (!redirect_valid && (!w_full || w_pop)) w_state_next = ST_REQ;
      end
      ST_REQ: begin
        if (imem_ack && !redirect_valid) begin
          w_push          = 1'b1;
          w_fetch_pc_next = r_fetch_pc + PC_STEP;
          w_state_next    = ((w_count + CNT_W'(1) - CNT_W'(w_pop)) < DEPTH_C) ? ST_REQ : ST_IDLE;
        end
      end
      ST_DROP: begin
        if (imem_ack) w_state_next = (!w_full || w_pop) ? ST_REQ : ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase

    // Redirect flushes the FIFO, so any outstanding slot is free afterwards
    if (redirect_valid) begin
      w_fetch_pc_next = w_redirect_pc;
      case (r_state)
        ST_REQ: begin
          if (imem_ack) begin
            w_state_next = ST_REQ;
          end else begin
            w_state_next     = ST_DROP;
            w_drop_addr_next = r_fetch_pc;
          end
        end
        ST_DROP: w_state_next = imem_ack ? ST_REQ : ST_DROP;
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sm_fetch_unit.sv
// Directed bench for sm_fetch_unit with a latency-programmable imem model.
module tb_sm_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        instr_valid, instr_ready = 1'b0;
  logic [31:0] instr, instr_pc;
  logic [11:0] instr_cmd;
  logic        instr_is_branch;

  int          lat = 0;
  logic        force_ack = 1'b0;
  int          wait_cnt = 0;
  int          n_ack = 0;
  int          n_pop = 0;
  logic [31:0] last_pop_pc = 32'd0;
  int          n_vec = 0;
  int          n_err = 0;

`ifdef SM_FETCH_PREDECODE_EN
  localparam bit PD = 1'b1;
`else
  localparam bit PD = 1'b0;
`endif

  sm_fetch_unit #(.FIFO_DEPTH(2), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_cmd       (instr_cmd),
    .instr_is_branch (instr_is_branch)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h2409_0005;
      32'h0000_0004: return 32'h0000_0000;
      32'h0000_0100: return 32'h1000_FFFF;
      default:       return {8'h24, a[23:0]};
    endcase
  endfunction

  assign imem_ack   = force_ack | (imem_req && (wait_cnt >= lat));
  assign imem_rdata = mem_word(imem_addr);

  always @(posedge clk) begin
    if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
    else                       wait_cnt <= 0;
    if (imem_req && imem_ack) n_ack <= n_ack + 1;
    if (instr_valid && instr_ready) begin
      n_pop       <= n_pop + 1;
      last_pop_pc <= instr_pc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int l, input logic rdy);
    rst = 1'b1;
    redirect_valid = 1'b0;
    force_ack = 1'b0;
    lat = l;
    instr_ready = rdy;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int base, pbase;
    logic [31:0] exp_pc;
    bit seen;

    // Reset values and zero-wait streaming
    do_reset(0, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_req",   {31'd0, imem_req}, 32'd0);
    chk("rst_addr",  imem_addr, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc",    instr_pc, 32'd0);
    chk("rst_cmd",   {20'd0, instr_cmd}, 32'd0);
    chk("rst_br",    {31'd0, instr_is_branch}, 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("s1_req",    {31'd0, imem_req}, 32'd1);
    chk("s1_addr0",  imem_addr, 32'h0);
    chk("s1_nvalid", {31'd0, instr_valid}, 32'd0);
    step();
    chk("s1_valid",  {31'd0, instr_valid}, 32'd1);
    chk("s1_pc0",    instr_pc, 32'h0);
    chk("s1_instr0", instr, 32'h2409_0005);
    // {001001, 000101} from the word's opcode and funct fields
    chk("s1_cmd0",   {20'd0, instr_cmd}, PD ? 32'h245 : 32'h0);
    chk("s1_br0",    {31'd0, instr_is_branch}, 32'd0);
    chk("s1_addr4",  imem_addr, 32'h4);
    step();
    chk("s1_pc4",    instr_pc, 32'h4);
    chk("s1_addr8",  imem_addr, 32'h8);
    step();
    chk("s1_pc8",    instr_pc, 32'h8);
    chk("s1_addrC",  imem_addr, 32'hC);

    // Back-pressure: only two words buffered, then no loss or duplication
    do_reset(0, 1'b0);
    base = n_ack;
    repeat (10) step();
    chk("s2_req_off", {31'd0, imem_req}, 32'd0);
    chk("s2_acks",    n_ack - base, 32'd2);
    chk("s2_valid",   {31'd0, instr_valid}, 32'd1);
    instr_ready = 1'b1;
    exp_pc = 32'h0;
    for (int i = 0; i < 8; i++) begin
      chk("s2_stream_valid", {31'd0, instr_valid}, 32'd1);
      chk("s2_stream_pc", instr_pc, exp_pc);
      exp_pc = exp_pc + 32'd4;
      step();
    end

    // Slow memory, redirect in the first cycle of a request
    do_reset(3, 1'b1);
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    chk("s3_req_held",  {31'd0, imem_req}, 32'd1);
    chk("s3_addr_held", imem_addr, 32'h0);
    step();
    step();
    step();
    chk("s3_addr_new",  imem_addr, 32'h100);
    chk("s3_nvalid",    {31'd0, instr_valid}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (instr_valid) seen = 1'b1;
      else step();
    end
    chk("s3_timeout", {31'd0, seen}, 32'd1);
    chk("s3_pc",      instr_pc, 32'h100);
    chk("s3_instr",   instr, 32'h1000_FFFF);
    chk("s3_br",      {31'd0, instr_is_branch}, PD ? 32'd1 : 32'd0);
    chk("s3_cmd",     {20'd0, instr_cmd}, PD ? 32'h13F : 32'h0);

    // Redirect coincident with ack and pop
    do_reset(0, 1'b1);
    step();
    step();
    chk("s4_head_pc", instr_pc, 32'h0);
    chk("s4_ack",     {31'd0, imem_ack}, 32'd1);
    pbase = n_pop;
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    chk("s4_flushed", {31'd0, instr_valid}, 32'd0);
    chk("s4_addr",    imem_addr, 32'h200);
    chk("s4_popped",  n_pop - pbase, 32'd1);
    chk("s4_pop_pc",  last_pop_pc, 32'h0);
    step();
    chk("s4_new_pc",  instr_pc, 32'h200);
    chk("s4_new_ins", instr, 32'h2400_0200);

    // Misaligned redirect near the top of memory, then wrap
    do_reset(0, 1'b1);
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    step();
    redirect_valid = 1'b0;
    chk("s5_addr_top",  imem_addr, 32'hFFFF_FFFC);
    step();
    chk("s5_addr_wrap", imem_addr, 32'h0);
    chk("s5_pc_top",    instr_pc, 32'hFFFF_FFFC);
    step();
    chk("s5_pc_wrap",   instr_pc, 32'h0);

    // Reset mid-request, then a stray ack while idle
    do_reset(3, 1'b1);
    step();
    chk("s6_req",      {31'd0, imem_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("s6_async_req", {31'd0, imem_req}, 32'd0);
    step();
    rst = 1'b0;
    force_ack = 1'b1;
    step();
    force_ack = 1'b0;
    chk("s6_stray",    {31'd0, instr_valid}, 32'd0);
    step();
    chk("s6_stray2",   {31'd0, instr_valid}, 32'd0);
    chk("s6_addr",     imem_addr, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
